// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared constants for the nibble-serial adder slice: nibble width,
//   control FSM state encodings and the nibble-index width helper.
//   No ports (package).
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the nibble index register: clog2 of the nibble count,
  // never narrower than one bit.
  function automatic int idx_w(input int nibbles);
    int w;
    w = $clog2(nibbles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Operand/result handshake bundle for nibble_serial_adder.
//   Parameter NIBBLES sets the operand width W = 4*NIBBLES.
//   Signals:
//     in_valid/in_ready  operand pair handshake (master -> slave)
//     a, b, cin          operands and carry-in
//     out_valid/out_ready result handshake (slave -> master)
//     sum, cout          wide sum and carry-out
//     ovf                signed overflow (only with NIBBLE_SERIAL_ADDER_OVF_EN)
//   Modports: master (producer/consumer side), slave (adder side).
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// ripple_carry_adder_4bit
//   Purely combinational 4-bit ripple-carry adder, the shared datapath of
//   the nibble-serial sequencer.
//   Ports:
//     a_i, b_i   4-bit operands
//     cin_i      carry-in
//     sum_o      4-bit sum
//     cout_o     carry-out of bit 3
module ripple_carry_adder_4bit
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic c_v;

  always_comb begin
    sum_o = '0;
    c_v   = cin_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c_v;
      c_v      = (a_i[i] & b_i[i]) | (c_v & (a_i[i] ^ b_i[i]));
    end
    cout_o = c_v;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Accepts a W-bit operand pair (W = 4*NIBBLES) over a valid/ready
//   handshake, adds it one nibble per cycle (LSB nibble first) through a
//   single ripple_carry_adder_4bit with the carry kept in a register, and
//   returns {cout,sum} = a + b + cin over a valid/ready handshake.
//   Latency: result visible to the consumer NIBBLES+1 edges after accept;
//   one operation per NIBBLES+2 cycles with out_ready held high.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    nibble_serial_adder_if.slave (in_valid/in_ready, a, b, cin,
//            out_valid/out_ready, sum, cout[, ovf])
//   Optional feature: define NIBBLE_SERIAL_ADDER_OVF_EN to add bus.ovf,
//   the signed two's-complement overflow of the W-bit add.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_w(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  ripple_carry_adder_4bit u_rca (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // Carry into the MSB xor carry out equals "operand signs agree but the
  // result sign differs", which needs only the top-nibble MSBs.
  assign ovf_d   = (a_nib[NIBBLE_W-1] ~^ b_nib[NIBBLE_W-1]) &
                   (a_nib[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1]);
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the accept.
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_sum;
          carry_q <= nib_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q      <= nib_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(N)) bus ();

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide integer add; overflow from the signed range.
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    res_t       r;
    logic [W:0] t;
    int         sa, sbv, ciw, st;
    t   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    sa  = $signed(av);
    sbv = $signed(bv);
    ciw = ci ? 1 : 0;
    st  = sa + sbv + ciw;
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = (st > 32767) || (st < -32768);
    return r;
  endfunction

  task automatic check_result(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, bus.sum, e.s);
      chk({tag, "_cout"}, bus.cout, e.c);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk({tag, "_ovf"}, bus.ovf, e.v);
`endif
    end
  endtask

  // Starts and ends on a negedge; the accept edge is the posedge in between.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, input bit push);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.cin = ci;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    if (push) sb.push_back(model(av, bv, ci));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~av;
    bus.b = ~bv;
    bus.cin = ~ci;
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) chk({tag, "_timeout"}, bus.out_valid, 1);
  endtask

  task automatic get_result(input string tag);
    wait_out(tag);
    check_result(tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, ov, nres, k;
    int   t_acc[3];
    logic [W-1:0] op_a[3];
    logic [W-1:0] op_b[3];
    logic op_c[3];
    logic ir, ovl, c_s;
    logic [W-1:0] s_s;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic v_s;
`endif
    res_t e;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1 + 2, with latency measured in edges until the result is presented
    accept(16'h0001, 16'h0002, 1'b0, 1);
    cyc = 0;
    ov = 0;
    while (cyc < 50) begin
      ov = bus.out_valid;
      @(posedge clk);
      cyc++;
      if (ov) break;
      @(negedge clk);
    end
    chk("latency", cyc, 5);
    @(negedge clk);
    check_result("t1");
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t1_release_out_valid", bus.out_valid, 0);
    chk("t1_release_in_ready", bus.in_ready, 1);

    // Full-width carry ripple
    accept(16'hFFFF, 16'h0001, 1'b0, 1);
    get_result("t2");

    // Back-to-back with out_ready held high
    op_a[0] = 16'hAAAA; op_b[0] = 16'h5555; op_c[0] = 1'b1;
    op_a[1] = 16'h1234; op_b[1] = 16'h0FED; op_c[1] = 1'b0;
    op_a[2] = 16'h8001; op_b[2] = 16'h7FFF; op_c[2] = 1'b1;
    bus.out_ready = 1'b1;
    k = 0;
    nres = 0;
    cyc = 0;
    while (nres < 3 && cyc < 100) begin
      if (k < 3) begin
        bus.in_valid = 1'b1;
        bus.a = op_a[k];
        bus.b = op_b[k];
        bus.cin = op_c[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      ir  = bus.in_ready;
      ovl = bus.out_valid;
      s_s = bus.sum;
      c_s = bus.cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      v_s = bus.ovf;
`endif
      @(posedge clk);
      cyc++;
      if (ir && bus.in_valid && k < 3) begin
        sb.push_back(model(op_a[k], op_b[k], op_c[k]));
        t_acc[k] = cyc;
        k++;
      end
      if (ovl) begin
        e = sb.pop_front();
        chk("b2b_sum", s_s, e.s);
        chk("b2b_cout", c_s, e.c);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("b2b_ovf", v_s, e.v);
`endif
        nres++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("b2b_results", nres, 3);
    chk("b2b_period_01", t_acc[1] - t_acc[0], 6);
    chk("b2b_period_12", t_acc[2] - t_acc[1], 6);

    // Consumer stall with new operands offered
    accept(16'h0F0F, 16'h0101, 1'b0, 1);
    wait_out("stall");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'h1000 * (i + 1);
      bus.b = 16'h0321;
      bus.cin = 1'b1;
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_sum", bus.sum, sb[0].s);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    get_result("stall_rel");
    accept(16'h1111, 16'h2222, 1'b1, 1);
    get_result("after_stall");

    // Reset in the second RUN cycle aborts the operation
    accept(16'hDEAD, 16'hBEEF, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_sum", bus.sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    chk("abort_no_result", ov, 0);
    accept(16'h1234, 16'h4321, 1'b0, 1);
    get_result("post_abort");

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    accept(16'h7FFF, 16'h0001, 1'b0, 1);
    get_result("ovf_pos");
    accept(16'h8000, 16'hFFFF, 1'b0, 1);
    get_result("ovf_neg");
`endif

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
